// File: rtl/layer_weight_initializer.sv
// Fills the N_NEURONS x N_INPUTS weight bank of one fully-connected layer
// with a constant, a Galois LFSR sequence, or words streamed over valid/ready.
module layer_weight_initializer #(
    parameter int N_NEURONS  = 3,
    parameter int N_INPUTS   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start,
    input  logic [1:0]                               mode,
    input  logic [DATA_WIDTH-1:0]                    init_val,
    input  logic [31:0]                              seed,
    input  logic [DATA_WIDTH-1:0]                    in_data,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    output logic [N_NEURONS*N_INPUTS*DATA_WIDTH-1:0] weights,
    output logic                                     wr_en,
    output logic [CNT_W-1:0]                         wr_neuron,
    output logic [CNT_W-1:0]                         wr_index,
    output logic                                     busy,
    output logic                                     done
);

    localparam int          NW         = N_NEURONS * N_INPUTS;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [1:0]  MODE_LFSR  = 2'd1;
    localparam logic [1:0]  MODE_STRM  = 2'd2;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_INPUTS - 1);
    localparam logic [CNT_W-1:0] LAST_NRN = CNT_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [1:0]              mode_q;
    logic [DATA_WIDTH-1:0]   init_q;
    logic [31:0]             lfsr_q;
    logic [31:0]             lfsr_d;
    logic [CNT_W-1:0]        nrn_q;
    logic [CNT_W-1:0]        idx_q;
    logic                    wr_en_q;
    logic [CNT_W-1:0]        wr_neuron_q;
    logic [CNT_W-1:0]        wr_index_q;
    logic                    fire;
    logic [DATA_WIDTH-1:0]   wdata_d;

    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        // Stream mode only advances on a handshake; other modes write every FILL cycle.
        fire = (state_q == S_FILL) && ((mode_q != MODE_STRM) || in_valid);
        case (mode_q)
            MODE_LFSR: wdata_d = lfsr_q[DATA_WIDTH-1:0];
            MODE_STRM: wdata_d = in_data;
            default:   wdata_d = init_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            init_q      <= '0;
            lfsr_q      <= '0;
            nrn_q       <= '0;
            idx_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_neuron_q <= '0;
            wr_index_q  <= '0;
        end else begin
            wr_en_q <= fire;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_FILL;
                        mode_q  <= mode;
                        init_q  <= init_val;
                        lfsr_q  <= (seed == 32'd0) ? 32'd1 : seed;
                        nrn_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                S_FILL: begin
                    if (fire) begin
                        wr_neuron_q <= nrn_q;
                        wr_index_q  <= idx_q;
                        if (mode_q == MODE_LFSR) begin
                            lfsr_q <= lfsr_d;
                        end
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (nrn_q == LAST_NRN) begin
                                nrn_q   <= '0;
                                state_q <= S_DONE;
                            end else begin
                                nrn_q <= nrn_q + 1'b1;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // One register per word, enabled when the counters address it.
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_word
            localparam logic [CNT_W-1:0] WN = CNT_W'(gi / N_INPUTS);
            localparam logic [CNT_W-1:0] WK = CNT_W'(gi % N_INPUTS);
            logic [DATA_WIDTH-1:0] word_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    word_q <= '0;
                end else if (fire && (nrn_q == WN) && (idx_q == WK)) begin
                    word_q <= wdata_d;
                end
            end

            assign weights[gi*DATA_WIDTH +: DATA_WIDTH] = word_q;
        end
    endgenerate

    assign in_ready  = (state_q == S_FILL) && (mode_q == MODE_STRM);
    assign busy      = (state_q == S_FILL);
    assign done      = (state_q == S_DONE);
    assign wr_en     = wr_en_q;
    assign wr_neuron = wr_neuron_q;
    assign wr_index  = wr_index_q;

endmodule

// File: tb/tb_layer_weight_initializer.sv
// Scoreboard bench: expected writes are queued when a fill is launched and
// popped on every wr_en strobe; a second instance covers a 4x5x8 layer.
module tb_layer_weight_initializer;

    typedef struct {
        logic [7:0]  n;
        logic [7:0]  k;
        logic [31:0] d;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         start6 = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [31:0]  init_val = '0;
    logic [31:0]  seed = '0;
    logic [31:0]  in_data = '0;
    logic         in_valid = 1'b0;

    logic         in_ready, wr_en, busy, done;
    logic [191:0] weights;
    logic [7:0]   wr_neuron, wr_index;

    logic         in_ready6, wr_en6, busy6, done6;
    logic [159:0] weights6;
    logic [7:0]   wr_neuron6, wr_index6;

    exp_t sb[$];
    exp_t sb6[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    layer_weight_initializer u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .init_val(init_val), .seed(seed), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .weights(weights), .wr_en(wr_en),
        .wr_neuron(wr_neuron), .wr_index(wr_index), .busy(busy), .done(done)
    );

    layer_weight_initializer #(
        .N_NEURONS(4), .N_INPUTS(5), .DATA_WIDTH(8), .CNT_W(8)
    ) u_dut6 (
        .clk(clk), .rst(rst), .start(start6), .mode(mode),
        .init_val(init_val[7:0]), .seed(seed), .in_data(in_data[7:0]), .in_valid(in_valid),
        .in_ready(in_ready6), .weights(weights6), .wr_en(wr_en6),
        .wr_neuron(wr_neuron6), .wr_index(wr_index6), .busy(busy6), .done(done6)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    task automatic push_fill(input int nn, input int ni, input logic [1:0] m,
                             input logic [31:0] v, input logic [31:0] s);
        logic [31:0] st;
        exp_t e;
        st = (s == 32'd0) ? 32'd1 : s;
        for (int n = 0; n < nn; n++) begin
            for (int k = 0; k < ni; k++) begin
                e.n = 8'(n);
                e.k = 8'(k);
                e.d = (m == 2'd1) ? st : v;
                st  = lfsr_step(st);
                if (nn == 3) sb.push_back(e);
                else         sb6.push_back(e);
            end
        end
    endtask

    task automatic start_fill(input logic [1:0] m, input logic [31:0] v, input logic [31:0] s);
        mode = m;
        init_val = v;
        seed = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (weights !== '0 || weights6 !== '0) begin
            n_fail++; $display("FAIL reset_weights: got %h / %h, want 0", weights, weights6);
        end
        n_checks++;
        if ({wr_en, busy, done, in_ready, wr_neuron, wr_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: wr_en=%b busy=%b done=%b in_ready=%b n=%0d k=%0d, want all 0",
                     wr_en, busy, done, in_ready, wr_neuron, wr_index);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        $display("reset: checked idle state");
    endtask

    task automatic test_const();
        int writes = 0, busy_cnt = 0, first = -1, last = -1;
        bit fin = 0;
        exp_t e;
        push_fill(3, 2, 2'd0, 32'd1, 32'd0);
        start_fill(2'd0, 32'd1, 32'd0);
        for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (wr_en) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL const_extra_write: got n=%0d k=%0d, want none", wr_neuron, wr_index);
                end else begin
                    e = sb.pop_front();
                    if (wr_neuron !== e.n || wr_index !== e.k || weights[(e.n*2+e.k)*32 +: 32] !== e.d) begin
                        n_fail++;
                        $display("FAIL const_write: got (%0d,%0d)=%h, want (%0d,%0d)=%h", wr_neuron, wr_index,
                                 weights[(e.n*2+e.k)*32 +: 32], e.n, e.k, e.d);
                    end
                end
                $display("const: write %0d (%0d,%0d)", writes, wr_neuron, wr_index);
                writes++;
                if (first < 0) first = c;
                last = c;
            end
            if (done) fin = 1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!fin || writes != 6 || busy_cnt != 6 || (last - first) != 5 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL const_counts: done=%0d writes=%0d busy=%0d span=%0d left=%0d, want 1/6/6/5/0",
                     fin, writes, busy_cnt, last - first, sb.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (weights[i*32 +: 32] !== 32'd1) begin
                n_fail++; $display("FAIL const_bank[%0d]: got %h, want 1", i, weights[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_lfsr();
        logic [31:0] ref_s;
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            int writes = 0;
            bit fin = 0;
            push_fill(3, 2, 2'd1, 32'd0, 32'(r));
            start_fill(2'd1, 32'd0, 32'(r));
            for (int c = 0; c < 20 && !fin; c++) begin
                @(negedge clk);
                if (wr_en) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL lfsr_extra_write: got n=%0d k=%0d, want none", wr_neuron, wr_index);
                    end else begin
                        e = sb.pop_front();
                        if (wr_neuron !== e.n || wr_index !== e.k || weights[(e.n*2+e.k)*32 +: 32] !== e.d) begin
                            n_fail++;
                            $display("FAIL lfsr_write seed=%0d: got (%0d,%0d)=%h, want (%0d,%0d)=%h", r,
                                     wr_neuron, wr_index, weights[(e.n*2+e.k)*32 +: 32], e.n, e.k, e.d);
                        end
                    end
                    $display("lfsr seed=%0d: write %0d (%0d,%0d)", r, writes, wr_neuron, wr_index);
                    writes++;
                end
                if (done) fin = 1;
                @(posedge clk); #1;
            end
            n_checks++;
            if (!fin || writes != 6) begin
                n_fail++; $display("FAIL lfsr_count seed=%0d: done=%0d writes=%0d, want 1/6", r, fin, writes);
            end
            n_checks++;
            if (weights[31:0] !== 32'd1 || weights[63:32] !== 32'h8020_0003) begin
                n_fail++;
                $display("FAIL lfsr_first_words seed=%0d: got %h %h, want 00000001 80200003",
                         r, weights[31:0], weights[63:32]);
            end
            ref_s = 32'd1;
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (weights[i*32 +: 32] !== ref_s) begin
                    n_fail++; $display("FAIL lfsr_bank[%0d] seed=%0d: got %h, want %h", i, r, weights[i*32 +: 32], ref_s);
                end
                ref_s = lfsr_step(ref_s);
            end
        end
    endtask

    task automatic test_stream();
        int writes = 0, sent = 0;
        bit fin = 0;
        bit wr_hist[14];
        exp_t e;
        start_fill(2'd2, 32'd0, 32'd0);
        for (int c = 0; c < 14; c++) begin
            in_valid = (c <= 2) || (c >= 5 && c <= 7) || (c >= 10);
            in_data  = (c <= 2) ? 32'(10 + c) : (c <= 7) ? 32'(13 + c - 5) : 32'd99;
            if (in_valid && c <= 7) begin
                e.n = 8'(sent / 2);
                e.k = 8'(sent % 2);
                e.d = in_data;
                sb.push_back(e);
                sent++;
            end
            @(negedge clk);
            n_checks++;
            if (in_ready !== busy) begin
                n_fail++; $display("FAIL stream_ready c=%0d: got %b, want %b", c, in_ready, busy);
            end
            wr_hist[c] = wr_en;
            if (wr_en) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra_write c=%0d: got n=%0d k=%0d, want none", c, wr_neuron, wr_index);
                end else begin
                    e = sb.pop_front();
                    if (wr_neuron !== e.n || wr_index !== e.k || weights[(e.n*2+e.k)*32 +: 32] !== e.d) begin
                        n_fail++;
                        $display("FAIL stream_write: got (%0d,%0d)=%0d, want (%0d,%0d)=%0d", wr_neuron, wr_index,
                                 weights[(e.n*2+e.k)*32 +: 32], e.n, e.k, e.d);
                    end
                end
                $display("stream: cycle %0d write (%0d,%0d)", c, wr_neuron, wr_index);
                writes++;
            end
            if (done) fin = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!fin || writes != 6 || wr_hist[4] || wr_hist[5] || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_counts: done=%0d writes=%0d stall_wr=%b%b left=%0d, want 1/6/00/0",
                     fin, writes, wr_hist[4], wr_hist[5], sb.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (weights[i*32 +: 32] !== 32'(10 + i)) begin
                n_fail++; $display("FAIL stream_bank[%0d]: got %0d, want %0d", i, weights[i*32 +: 32], 10 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            logic [31:0] v;
            int writes = 0;
            bit fin = 0;
            v = (r == 0) ? 32'd5 : 32'd7;
            push_fill(3, 2, 2'd0, v, 32'd0);
            start_fill(2'd0, v, 32'd0);
            for (int c = 0; c < 20 && !fin; c++) begin
                if (r == 0 && c == 2) begin
                    start = 1'b1;
                    init_val = 32'd9;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                if (wr_en) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++; $display("FAIL restart_extra_write: got n=%0d k=%0d, want none", wr_neuron, wr_index);
                    end else begin
                        e = sb.pop_front();
                        if (wr_neuron !== e.n || wr_index !== e.k || weights[(e.n*2+e.k)*32 +: 32] !== e.d) begin
                            n_fail++;
                            $display("FAIL restart_write: got (%0d,%0d)=%0d, want (%0d,%0d)=%0d", wr_neuron, wr_index,
                                     weights[(e.n*2+e.k)*32 +: 32], e.n, e.k, e.d);
                        end
                    end
                    $display("restart pass %0d: write %0d (%0d,%0d)", r, writes, wr_neuron, wr_index);
                    writes++;
                end
                if (done) fin = 1;
                @(posedge clk); #1;
            end
            start = 1'b0;
            n_checks++;
            if (!fin || writes != 6 || sb.size() != 0) begin
                n_fail++; $display("FAIL restart_count pass %0d: done=%0d writes=%0d, want 1/6", r, fin, writes);
            end
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (weights[i*32 +: 32] !== v) begin
                    n_fail++; $display("FAIL restart_bank[%0d] pass %0d: got %0d, want %0d", i, r, weights[i*32 +: 32], v);
                end
            end
        end
    endtask

    task automatic test_reset_midfill();
        int writes = 0;
        exp_t e;
        push_fill(3, 2, 2'd0, 32'd2, 32'd0);
        start_fill(2'd0, 32'd2, 32'd0);
        for (int c = 0; c < 20 && writes < 3; c++) begin
            @(negedge clk);
            if (wr_en) begin
                writes++;
                e = sb.pop_front();
                n_checks++;
                if (weights[(e.n*2+e.k)*32 +: 32] !== 32'd2) begin
                    n_fail++; $display("FAIL midrst_write: got %0d, want 2", weights[(e.n*2+e.k)*32 +: 32]);
                end
                $display("midrst: write %0d (%0d,%0d)", writes, wr_neuron, wr_index);
            end
            if (writes < 3) begin
                @(posedge clk); #1;
            end
        end
        n_checks++;
        if (writes != 3) begin
            n_fail++; $display("FAIL midrst_timeout: got %0d writes, want 3", writes);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (weights !== '0 || busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: weights=%h busy=%b wr_en=%b done=%b, want 0", weights, busy, wr_en, done);
        end
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_idle: busy=%b done=%b wr_en=%b, want 0", busy, done, wr_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wide();
        int writes = 0, wraps = 0, prev_k = -1, prev_n = -1;
        bit fin = 0;
        exp_t e;
        push_fill(4, 5, 2'd0, 32'hA5, 32'd0);
        mode = 2'd0;
        init_val = 32'hA5;
        start6 = 1'b1;
        @(posedge clk); #1;
        start6 = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (wr_en6) begin
                n_checks++;
                if (sb6.size() == 0) begin
                    n_fail++; $display("FAIL wide_extra_write: got n=%0d k=%0d, want none", wr_neuron6, wr_index6);
                end else begin
                    e = sb6.pop_front();
                    if (wr_neuron6 !== e.n || wr_index6 !== e.k || weights6[(e.n*5+e.k)*8 +: 8] !== e.d[7:0]) begin
                        n_fail++;
                        $display("FAIL wide_write: got (%0d,%0d)=%h, want (%0d,%0d)=%h", wr_neuron6, wr_index6,
                                 weights6[(e.n*5+e.k)*8 +: 8], e.n, e.k, e.d[7:0]);
                    end
                end
                if (prev_k == 4) begin
                    n_checks++;
                    wraps++;
                    if (wr_index6 !== 8'd0 || wr_neuron6 !== 8'(prev_n + 1)) begin
                        n_fail++;
                        $display("FAIL wide_wrap: got (%0d,%0d), want (%0d,0)", wr_neuron6, wr_index6, prev_n + 1);
                    end
                end
                $display("wide: write %0d (%0d,%0d)", writes, wr_neuron6, wr_index6);
                prev_k = int'(wr_index6);
                prev_n = int'(wr_neuron6);
                writes++;
            end
            if (done6) fin = 1;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!fin || writes != 20 || wraps != 3 || sb6.size() != 0) begin
            n_fail++;
            $display("FAIL wide_counts: done=%0d writes=%0d wraps=%0d left=%0d, want 1/20/3/0",
                     fin, writes, wraps, sb6.size());
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (weights6[i*8 +: 8] !== 8'hA5) begin
                n_fail++; $display("FAIL wide_bank[%0d]: got %h, want a5", i, weights6[i*8 +: 8]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const();
        test_lfsr();
        test_stream();
        test_back_to_back();
        test_reset_midfill();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
